// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run-control sequencer for the pipelined cpu core. A host streams a program
// into instruction memory through the cpu external write port; the block then
// enables the core for a bounded (i_max_cycles) or host-stopped (i_stop) run,
// keeps the core enabled for DRAIN_CYCLES more cycles to flush the 5-stage
// pipeline, parks it and reports completion plus the RUN cycle count.
//
// Ports
//   i_clk            clock
//   i_arst_n         synchronous active-low reset
//   i_start          pulse: begin load+run (run only when i_skip_load=1)
//   i_skip_load      sampled with i_start: go straight to RUN
//   i_stop           pulse: end RUN early
//   i_max_cycles     RUN length limit sampled on i_start, 0 = unlimited
//   i_load_valid     host word valid
//   i_load_data      host instruction word
//   i_load_last      marks the final program word
//   o_load_ready     word accepted this cycle (decoded from state)
//   o_imem_addr_ext  byte address to cpu addr_ext
//   o_imem_wen_ext   write enable to cpu wen_ext
//   o_imem_wdata_ext write data to cpu wdata_ext
//   o_cpu_en         cpu enable
//   o_busy           state is LOAD, RUN or DRAIN
//   o_done           state is DONE
//   o_load_ovf       memory filled without a last word
//   o_cycle_count    RUN cycles elapsed (saturating)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int IMEM_ADDR_W  = 9,
  parameter int DRAIN_CYCLES = 4,
  parameter int CYC_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic             i_skip_load,
  input  logic             i_stop,
  input  logic [CYC_W-1:0] i_max_cycles,
  input  logic             i_load_valid,
  input  logic [31:0]      i_load_data,
  input  logic             i_load_last,
  output logic             o_load_ready,
  output logic [31:0]      o_imem_addr_ext,
  output logic             o_imem_wen_ext,
  output logic [31:0]      o_imem_wdata_ext,
  output logic             o_cpu_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_load_ovf,
  output logic [CYC_W-1:0] o_cycle_count
);

  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(DRAIN_LAST_I);
  localparam logic [DRAIN_W-1:0]     DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [IMEM_ADDR_W-1:0] IDX_ONE    = IMEM_ADDR_W'(1);
  localparam logic [CYC_W-1:0]       CNT_ONE    = CYC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [IMEM_ADDR_W-1:0] r_word_idx;
  logic [CYC_W-1:0]       r_max;
  logic [DRAIN_W-1:0]     r_drain_cnt;
  logic [31:0]            r_imem_addr;
  logic                   r_imem_wen;
  logic [31:0]            r_imem_wdata;
  logic                   r_cpu_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_load_ovf;
  logic [CYC_W-1:0]       r_cycle_count;

  logic [31:0]            w_byte_addr;
  logic [CYC_W-1:0]       w_count_inc;
  logic                   w_max_hit;

  // Word index shifted into a byte address for the cpu external port.
  assign w_byte_addr = {{(30-IMEM_ADDR_W){1'b0}}, r_word_idx, 2'b00};

  // Count holds at all-ones instead of wrapping during very long runs.
  assign w_count_inc = (r_cycle_count == '1) ? r_cycle_count
                                             : r_cycle_count + CNT_ONE;

  // Compared against the pre-increment value so the final count equals max.
  assign w_max_hit = (r_max != '0) && (r_cycle_count == r_max - CNT_ONE);

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_state       <= S_IDLE;
      r_word_idx    <= '0;
      r_max         <= '0;
      r_drain_cnt   <= '0;
      r_imem_addr   <= '0;
      r_imem_wen    <= 1'b0;
      r_imem_wdata  <= '0;
      r_cpu_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_load_ovf    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      // The write strobe is a single-cycle pulse per accepted word.
      r_imem_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_word_idx    <= '0;
            r_cycle_count <= '0;
            r_load_ovf    <= 1'b0;
            r_done        <= 1'b0;
            r_max         <= i_max_cycles;
            r_busy        <= 1'b1;
            if (i_skip_load) begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
            end else begin
              r_state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (i_load_valid) begin
            r_imem_wen   <= 1'b1;
            r_imem_addr  <= w_byte_addr;
            r_imem_wdata <= i_load_data;
            r_word_idx   <= r_word_idx + IDX_ONE;
            // The core may start fetching while the last word is written:
            // fetch begins at address 0, which is already in memory.
            if (i_load_last) begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
            end else if (r_word_idx == '1) begin
              r_state    <= S_RUN;
              r_cpu_en   <= 1'b1;
              r_load_ovf <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_cycle_count <= w_count_inc;
          if (i_stop || w_max_hit) begin
            r_drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              r_state  <= S_DONE;
              r_cpu_en <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state  <= S_DONE;
            r_cpu_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_load_ready     = (r_state == S_LOAD);
  assign o_imem_addr_ext  = r_imem_addr;
  assign o_imem_wen_ext   = r_imem_wen;
  assign o_imem_wdata_ext = r_imem_wdata;
  assign o_cpu_en         = r_cpu_en;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_load_ovf       = r_load_ovf;
  assign o_cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed self-checking bench for cpu_run_ctrl. Two instances share the same
// stimulus: u_dut uses the default memory depth, u_small uses IMEM_ADDR_W=2 so
// the load-overflow path is reachable with four words.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic        skip_load;
  logic        stop;
  logic [31:0] max_cycles;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;

  logic        load_ready,   s_load_ready;
  logic [31:0] imem_addr,    s_imem_addr;
  logic        imem_wen,     s_imem_wen;
  logic [31:0] imem_wdata,   s_imem_wdata;
  logic        cpu_en,       s_cpu_en;
  logic        busy,         s_busy;
  logic        done,         s_done;
  logic        load_ovf,     s_load_ovf;
  logic [31:0] cycle_count,  s_cycle_count;

  int checks;
  int failures;

  cpu_run_ctrl #(.IMEM_ADDR_W(9), .DRAIN_CYCLES(4), .CYC_W(32)) u_dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_skip_load(skip_load),
    .i_stop(stop), .i_max_cycles(max_cycles), .i_load_valid(load_valid),
    .i_load_data(load_data), .i_load_last(load_last),
    .o_load_ready(load_ready), .o_imem_addr_ext(imem_addr),
    .o_imem_wen_ext(imem_wen), .o_imem_wdata_ext(imem_wdata),
    .o_cpu_en(cpu_en), .o_busy(busy), .o_done(done), .o_load_ovf(load_ovf),
    .o_cycle_count(cycle_count)
  );

  cpu_run_ctrl #(.IMEM_ADDR_W(2), .DRAIN_CYCLES(4), .CYC_W(32)) u_small (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_skip_load(skip_load),
    .i_stop(stop), .i_max_cycles(max_cycles), .i_load_valid(load_valid),
    .i_load_data(load_data), .i_load_last(load_last),
    .o_load_ready(s_load_ready), .o_imem_addr_ext(s_imem_addr),
    .o_imem_wen_ext(s_imem_wen), .o_imem_wdata_ext(s_imem_wdata),
    .o_cpu_en(s_cpu_en), .o_busy(s_busy), .o_done(s_done),
    .o_load_ovf(s_load_ovf), .o_cycle_count(s_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n     = 1'b0;
    start      = 1'b0;
    skip_load  = 1'b0;
    stop       = 1'b0;
    max_cycles = '0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    step();
    step();
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    max_cycles = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b0;
    step();
    load_data = 32'hCAFEF00D; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    step(); step(); step();
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_prerun_cpu_en: got %b expected 1", cpu_en); end
    arst_n = 1'b0;
    step();
    step();
    arst_n = 1'b1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_ready: got %b expected 0", load_ready); end
    checks++; if (imem_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen: got %b expected 0", imem_wen); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h expected 0", imem_wdata); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (load_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_ovf: got %b expected 0", load_ovf); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    step();
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_hold: got cpu_en=%b busy=%b expected 0 0", cpu_en, busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_restart: got busy=%b ready=%b expected 1 1", busy, load_ready); end
    checks++; if (imem_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_no_pending_write: got %b expected 0", imem_wen); end
  endtask

  task automatic test_load3_run();
    logic [31:0] words [3];
    int en_cycles;
    words[0] = 32'h20010005;
    words[1] = 32'h20020003;
    words[2] = 32'h00221820;
    do_reset();
    max_cycles = 32'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || load_ready !== 1'b1 || cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL load3_enter: got busy=%b ready=%b en=%b expected 1 1 0", busy, load_ready, cpu_en); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 2);
      step();
      checks++; if (imem_wen !== 1'b1) begin failures++; $display("[TB] FAIL load3_wen%0d: got %b expected 1", i, imem_wen); end
      checks++; if (imem_addr !== 32'(i * 4)) begin failures++; $display("[TB] FAIL load3_addr%0d: got %h expected %h", i, imem_addr, 32'(i * 4)); end
      checks++; if (imem_wdata !== words[i]) begin failures++; $display("[TB] FAIL load3_data%0d: got %h expected %h", i, imem_wdata, words[i]); end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++; if (cpu_en !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("[TB] FAIL load3_run_entry: got en=%b ready=%b expected 1 0", cpu_en, load_ready); end
    en_cycles = 1;
    for (int k = 0; k < 100 && done !== 1'b1; k++) begin
      step();
      if (cpu_en === 1'b1) en_cycles++;
      if (k == 0) begin
        checks++; if (imem_wen !== 1'b0) begin failures++; $display("[TB] FAIL load3_wen_drop: got %b expected 0", imem_wen); end
      end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL load3_done: got %b expected 1", done); end
    checks++; if (en_cycles != 14) begin failures++; $display("[TB] FAIL load3_en_cycles: got %0d expected 14", en_cycles); end
    checks++; if (cycle_count !== 32'd10) begin failures++; $display("[TB] FAIL load3_cycle_count: got %0d expected 10", cycle_count); end
    checks++; if (load_ovf !== 1'b0 || busy !== 1'b0 || cpu_en !== 1'b0) begin failures++; $display("[TB] FAIL load3_final: got ovf=%b busy=%b en=%b expected 0 0 0", load_ovf, busy, cpu_en); end
  endtask

  task automatic test_backpressure();
    logic       vpat [4];
    logic [31:0] eaddr;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
    do_reset();
    max_cycles = 32'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    eaddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      load_valid = vpat[i];
      load_data  = 32'hA0000000 + 32'(i);
      load_last  = (i == 3);
      step();
      checks++; if (imem_wen !== vpat[i]) begin failures++; $display("[TB] FAIL bp_wen%0d: got %b expected %b", i, imem_wen, vpat[i]); end
      if (vpat[i]) begin
        checks++; if (imem_addr !== eaddr || imem_wdata !== 32'hA0000000 + 32'(i)) begin failures++; $display("[TB] FAIL bp_write%0d: got addr=%h data=%h expected addr=%h", i, imem_addr, imem_wdata, eaddr); end
        eaddr = eaddr + 32'd4;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int k = 0; k < 50 && done !== 1'b1; k++) step();
    checks++; if (done !== 1'b1 || cycle_count !== 32'd2) begin failures++; $display("[TB] FAIL bp_done: got done=%b count=%0d expected 1 2", done, cycle_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    max_cycles = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hB0000000 + 32'(i);
      load_last  = 1'b0;
      step();
      checks++; if (s_imem_wen !== 1'b1 || s_imem_addr !== 32'(i * 4) || s_imem_wdata !== 32'hB0000000 + 32'(i)) begin failures++; $display("[TB] FAIL ovf_write%0d: got wen=%b addr=%h data=%h expected 1 %h", i, s_imem_wen, s_imem_addr, s_imem_wdata, 32'(i * 4)); end
      if (i < 3) begin
        checks++; if (s_load_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early%0d: got %b expected 0", i, s_load_ovf); end
      end
    end
    checks++; if (s_load_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", s_load_ovf); end
    checks++; if (s_cpu_en !== 1'b1 || s_load_ready !== 1'b0) begin failures++; $display("[TB] FAIL ovf_run: got en=%b ready=%b expected 1 0", s_cpu_en, s_load_ready); end
    load_data = 32'hB0000004;
    step();
    load_valid = 1'b0;
    checks++; if (s_imem_wen !== 1'b0) begin failures++; $display("[TB] FAIL ovf_fifth: got wen=%b expected 0", s_imem_wen); end
  endtask

  task automatic test_early_stop();
    do_reset();
    skip_load  = 1'b1;
    max_cycles = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    skip_load = 1'b0;
    checks++; if (cpu_en !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL stop_skip_entry: got en=%b ready=%b busy=%b expected 1 0 1", cpu_en, load_ready, busy); end
    for (int k = 0; k < 6; k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (cycle_count !== 32'd7 || cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL stop_count: got count=%0d en=%b expected 7 1", cycle_count, cpu_en); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (cpu_en !== 1'b1 || cycle_count !== 32'd7 || done !== 1'b0) begin failures++; $display("[TB] FAIL stop_drain%0d: got en=%b count=%0d done=%b expected 1 7 0", k, cpu_en, cycle_count, done); end
    end
    step();
    checks++; if (cpu_en !== 1'b0 || done !== 1'b1 || cycle_count !== 32'd7) begin failures++; $display("[TB] FAIL stop_done: got en=%b done=%b count=%0d expected 0 1 7", cpu_en, done, cycle_count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (done !== 1'b1 || cycle_count !== 32'd7) begin failures++; $display("[TB] FAIL stop_in_done: got done=%b count=%0d expected 1 7", done, cycle_count); end
  endtask

  task automatic test_ignored_start();
    do_reset();
    skip_load  = 1'b1;
    max_cycles = 32'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    skip_load = 1'b0;
    max_cycles = 32'd20;
    step();
    start = 1'b0;
    checks++; if (cycle_count !== 32'd3 || load_ready !== 1'b0 || cpu_en !== 1'b1) begin failures++; $display("[TB] FAIL ign_run_start: got count=%0d ready=%b en=%b expected 3 0 1", cycle_count, load_ready, cpu_en); end
    for (int k = 0; k < 50 && done !== 1'b1; k++) step();
    checks++; if (done !== 1'b1 || cycle_count !== 32'd5) begin failures++; $display("[TB] FAIL ign_run_done: got done=%b count=%0d expected 1 5", done, cycle_count); end
    max_cycles = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (done !== 1'b0 || cycle_count !== 32'd0 || busy !== 1'b1 || load_ready !== 1'b1) begin failures++; $display("[TB] FAIL ign_restart: got done=%b count=%0d busy=%b ready=%b expected 0 0 1 1", done, cycle_count, busy, load_ready); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load3_run();
    test_backpressure();
    test_overflow();
    test_early_stop();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the pipelined `cpu` core. It streams a program from a host into instruction memory over the `cpu` external instruction-memory port, then drives the `cpu` `enable` input for a bounded or host-stopped run. After the run it keeps `enable` high long enough to drain the 5-stage pipeline, then parks the core and reports completion and the cycle count.

## Interface

**Parameters**
- `IMEM_ADDR_W`, default 9: instruction memory depth is 2^IMEM_ADDR_W words.
- `DRAIN_CYCLES`, default 4: number of `enable` cycles granted after the run ends, to flush in-flight instructions.
- `CYC_W`, default 32: width of the cycle counter and `max_cycles`.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock for the whole block.
- `arst_n` in 1: reset, synchronous, active-low.
- `start` in 1: pulse; begins a load+run sequence (or a run only if `skip_load`=1).
- `skip_load` in 1: sampled with `start`; 1 = go straight to RUN.
- `stop` in 1: pulse; ends RUN early.
- `max_cycles` in CYC_W: RUN length limit, sampled on `start`; 0 = unlimited.
- `load_valid` in 1: host word valid.
- `load_data` in 32: host instruction word.
- `load_last` in 1: qualifies the final program word.
- `load_ready` out 1: block accepts a word this cycle.
- `imem_addr_ext` out 32: byte address to the `cpu` `addr_ext` input.
- `imem_wen_ext` out 1: to the `cpu` `wen_ext` input.
- `imem_wdata_ext` out 32: to the `cpu` `wdata_ext` input.
- `cpu_en` out 1: to the `cpu` `enable` input.
- `busy` out 1: state is LOAD, RUN or DRAIN.
- `done` out 1: state is DONE.
- `load_ovf` out 1: memory filled without `load_last`.
- `cycle_count` out CYC_W: RUN cycles elapsed.

## Operation

- **States:** IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE / DONE**
  - `start`=1 → LOAD, or RUN if `skip_load`=1.
  - On that same edge: clear `word_idx`, `cycle_count`, `load_ovf` and `done`; latch `max_cycles`.
- **LOAD**
  - `load_ready`=1.
  - A handshake is `load_valid & load_ready`. On each handshake, register `imem_wen_ext`=1, `imem_addr_ext = word_idx<<2` and `imem_wdata_ext = load_data`, then increment `word_idx`.
  - Handshake with `load_last`=1 → RUN.
  - Handshake at `word_idx` = 2^IMEM_ADDR_W−1 without `load_last` → RUN, and set `load_ovf`=1.
  - No handshake → `imem_wen_ext`=0.
- **RUN**
  - `cpu_en`=1.
  - `cycle_count` increments every RUN cycle and saturates at all-ones.
  - Exits to DRAIN when `stop`=1, or when latched max ≠ 0 and `cycle_count` = max−1. In the max case, the final count equals max.
- **DRAIN**
  - `cpu_en`=1 for exactly DRAIN_CYCLES cycles.
  - `cycle_count` frozen; then → DONE.
- **DONE:** `cpu_en`=0, `done`=1. `cycle_count` and `load_ovf` are held until the next `start`.
- **Ignored inputs:**
  - `load_valid` outside LOAD.
  - `start` in LOAD, RUN or DRAIN.
  - `stop` outside RUN.
- **Reset** (`arst_n`=0 at a clock edge, at any state including mid-LOAD or mid-RUN):
  - State returns to IDLE.
  - All outputs go to 0: `load_ready`, `imem_wen_ext`, `imem_addr_ext`, `imem_wdata_ext`, `cpu_en`, `busy`, `done`, `load_ovf`, `cycle_count`.
  - No pending write is issued after reset.

## Timing

- All outputs are registered. No combinational path from inputs to outputs, except `load_ready`, which is decoded from state only.
- `start` at edge N:
  - `busy`=1 from N+1.
  - `load_ready`=1 from N+1, or `cpu_en`=1 from N+1 if `skip_load`=1.
- Load write latency: a handshake at edge N drives `imem_wen_ext`/addr/data during cycle N+1, so the SRAM writes at edge N+2. Throughput is 1 word/cycle.
- The last-word handshake at edge N puts the state in RUN from N+1. `cpu_en` rises in the same cycle as the final `imem_wen_ext` pulse. This is legal because the CPU fetch port and the external port are independent; the first fetch is from address 0, which is already written.
- RUN of M cycles (max = M): `cpu_en` is high for M + DRAIN_CYCLES consecutive cycles; `done` rises the cycle after the last `cpu_en`=1 cycle.
- `stop` and max-reached in the same cycle: a single transition to DRAIN, with `cycle_count` = max.
- `stop` in the first RUN cycle: `cycle_count` = 1, then DRAIN.

## Test plan

- **Reset:** hold `arst_n`=0 for 2 cycles mid-RUN → next cycle all outputs 0 and state IDLE; a following `start` begins cleanly.
- **Load 3 words, then run:**
  - Stimulus: words 0x20010005, 0x20020003, 0x00221820 (`last` on the third), `max_cycles`=10.
  - Required: three `imem_wen_ext` pulses at addresses 0x0, 0x4, 0x8 with matching data; `cpu_en` high for exactly 14 cycles; `done`=1; `cycle_count`=10; `load_ovf`=0.
- **Backpressure / gaps:** `load_valid` toggling 1,0,0,1 → writes only on valid cycles; addresses stay contiguous (0x0, 0x4).
- **Overflow:** `IMEM_ADDR_W`=2, stream 4 words with no `last` → 4 writes at 0x0–0xC, `load_ovf`=1, state RUN after the 4th word; a 5th `load_valid` is not written.
- **Early stop:** `skip_load`=1, `max_cycles`=0, `stop` pulsed on the 7th RUN cycle → `cycle_count`=7, then 4 drain cycles, `done`=1.
- **Ignored start:** `start` pulsed during RUN → no effect. `start` pulsed in DONE → `done` falls, counters clear, LOAD re-entered.
